// File: rtl/pwm_carrier_pkg.sv
// Shared PWM types: run enable, carrier mode, carrier FSM states and default counter width.
package PKG_pwm;

    localparam int PWM_CNT_WIDTH = 16;

    typedef enum logic {PWM_OFF = 1'b0, PWM_ON = 1'b1} _pwm_onoff;

    typedef enum logic {CARR_SAW = 1'b0, CARR_TRI = 1'b1} _carr_mode;

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} _carr_state;

endpackage

// File: rtl/pwm_carrier_shadow_reg.sv
// Shadow registers for period/compare: loads while stopped, otherwise only at
// carrier-zero boundaries when an update is pending or requested.
module pwm_shadow_reg
    import PKG_pwm::*;
#(
    parameter int CNT_WIDTH = PWM_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 force_load_i,
    input  logic                 run_i,
    input  logic                 load_edge_i,
    input  logic                 upd_req_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    input  logic [CNT_WIDTH-1:0] compare_i,
    output logic [CNT_WIDTH-1:0] period_a_o,
    output logic [CNT_WIDTH-1:0] compare_a_o,
    output logic                 upd_ack_o
);

    logic [CNT_WIDTH-1:0] period_a_q, period_a_d;
    logic [CNT_WIDTH-1:0] compare_a_q, compare_a_d;
    logic                 pending_q, pending_d;
    logic                 upd_ack_q, upd_ack_d;

    always_comb begin
        period_a_d  = period_a_q;
        compare_a_d = compare_a_q;
        pending_d   = pending_q;
        upd_ack_d   = 1'b0;
        if (force_load_i) begin
            period_a_d  = period_i;
            compare_a_d = compare_i;
            pending_d   = 1'b0;
        end else if (load_edge_i && (pending_q || upd_req_i)) begin
            period_a_d  = period_i;
            compare_a_d = compare_i;
            pending_d   = 1'b0;
            upd_ack_d   = 1'b1;
        end else if (run_i && upd_req_i) begin
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_a_q  <= '0;
            compare_a_q <= '0;
            pending_q   <= 1'b0;
            upd_ack_q   <= 1'b0;
        end else begin
            period_a_q  <= period_a_d;
            compare_a_q <= compare_a_d;
            pending_q   <= pending_d;
            upd_ack_q   <= upd_ack_d;
        end
    end

    assign period_a_o  = period_a_q;
    assign compare_a_o = compare_a_q;
    assign upd_ack_o   = upd_ack_q;

endmodule

// File: rtl/pwm_carrier.sv
// Sawtooth / triangle PWM carrier with shadowed period and compare.
// Optional CARRIER_SYNC_EN adds a sync_in input that restarts the carrier phase.
module pwm_carrier
    import PKG_pwm::*;
#(
    parameter int CNT_WIDTH = PWM_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  _pwm_onoff            pwm_onoff,
    input  _carr_mode            mode,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] compare,
    input  logic [CNT_WIDTH-1:0] init,
    input  logic                 upd_req,
`ifdef CARRIER_SYNC_EN
    input  logic                 sync_in,
`endif
    output logic                 pwm,
    output logic [CNT_WIDTH-1:0] carrier,
    output logic                 zero_evt,
    output logic                 top_evt,
    output logic                 upd_ack
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    _carr_state           state_q, state_d;
    _carr_mode            mode_q, mode_d;
    logic [CNT_WIDTH-1:0] carrier_q, carrier_d;
    logic [CNT_WIDTH-1:0] period_a, compare_a;
    logic [CNT_WIDTH-1:0] start_val;
    logic                 pwm_q, pwm_d;
    logic                 running, keep_run, force_load, load_edge;

    assign running    = (state_q != IDLE);
    assign keep_run   = running && (pwm_onoff == PWM_ON);
    assign force_load = (pwm_onoff == PWM_OFF);
    assign start_val  = (init < period) ? init : period;
    assign load_edge  = keep_run && (carrier_d == '0);
    assign pwm_d      = running && (carrier_q < compare_a);

    // Stopping reloads carrier and shadows together so the carrier never exceeds period_a.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        carrier_d = carrier_q;
        case (state_q)
            IDLE: begin
                mode_d = mode;
                if (pwm_onoff == PWM_OFF) begin
                    carrier_d = start_val;
                end else begin
                    state_d = UP;
                end
            end
            UP, DOWN: begin
                if (pwm_onoff == PWM_OFF) begin
                    state_d   = IDLE;
                    carrier_d = start_val;
                end
`ifdef CARRIER_SYNC_EN
                else if (sync_in) begin
                    state_d   = UP;
                    carrier_d = (init < period_a) ? init : period_a;
                end
`endif
                else if (period_a == '0) begin
                    state_d   = UP;
                    carrier_d = '0;
                end else if (mode_q == CARR_SAW) begin
                    state_d   = UP;
                    carrier_d = (carrier_q == period_a) ? '0 : carrier_q + ONE;
                end else if (state_q == UP) begin
                    if (carrier_q == period_a) begin
                        state_d   = DOWN;
                        carrier_d = carrier_q - ONE;
                    end else begin
                        carrier_d = carrier_q + ONE;
                    end
                end else begin
                    if (carrier_q == '0) begin
                        state_d   = UP;
                        carrier_d = ONE;
                    end else begin
                        carrier_d = carrier_q - ONE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                carrier_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= CARR_SAW;
            carrier_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            carrier_q <= carrier_d;
            pwm_q     <= pwm_d;
        end
    end

    pwm_shadow_reg #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .force_load_i(force_load),
        .run_i       (keep_run),
        .load_edge_i (load_edge),
        .upd_req_i   (upd_req),
        .period_i    (period),
        .compare_i   (compare),
        .period_a_o  (period_a),
        .compare_a_o (compare_a),
        .upd_ack_o   (upd_ack)
    );

    assign pwm      = pwm_q;
    assign carrier  = carrier_q;
    assign zero_evt = running && (carrier_q == '0);
    assign top_evt  = running && (carrier_q == period_a);

endmodule
